// File: rtl/idx_key_table.sv
// Index-to-key reverse table: NR writable key slots addressed 1..NR (0 is reserved, always misses),
// read through a one-deep registered valid/ready response stage.
module idx_key_table #(
    parameter int unsigned NR = 2,
    parameter int unsigned KW = 1,
    parameter int unsigned IW = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [KW-1:0] wr_key,
    input  logic          clr_en,
    input  logic [IW-1:0] clr_idx,
    input  logic          clr_all,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [IW-1:0] req_idx,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [KW-1:0] rsp_key,
    output logic          rsp_hit,
    output logic [IW-1:0] count
);

    logic [NR-1:0]         valid_q, valid_d;
    logic [NR-1:0][KW-1:0] key_q, key_d;
    logic [IW-1:0]         count_q, count_d;
    logic                  rsp_valid_q, rsp_hit_q;
    logic [KW-1:0]         rsp_key_q;
    logic                  rd_hit;
    logic [KW-1:0]         rd_key;
    logic                  accept;

    // Update order clr_all -> clr_en -> wr_en, so a same-cycle write always wins.
    // Index 0 and indices above NR match no slot and are therefore ignored.
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        if (clr_all) begin
            valid_d = '0;
        end
        for (int i = 0; i < NR; i++) begin
            if (clr_en && clr_idx == IW'(i + 1)) begin
                valid_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (wr_en && wr_idx == IW'(i + 1)) begin
                valid_d[i] = 1'b1;
                key_d[i]   = wr_key;
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < NR; i++) begin
            count_d = count_d + IW'(valid_d[i]);
        end
    end

    // Lookup sees pre-update table state.
    always_comb begin
        rd_hit = 1'b0;
        rd_key = '0;
        for (int i = 0; i < NR; i++) begin
            if (req_idx == IW'(i + 1) && valid_q[i]) begin
                rd_hit = 1'b1;
                rd_key = key_q[i];
            end
        end
    end

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            key_q   <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            key_q   <= key_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_key_q   <= '0;
        end else if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= rd_hit;
            rsp_key_q   <= rd_key;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_key   = rsp_key_q;
    assign count     = count_q;

endmodule

// File: tb/tb_idx_key_table.sv
// Bench for idx_key_table (NR=4, KW=8): table-driven vectors with a response scoreboard,
// plus hand-written backpressure and async-reset sequences.
module tb_idx_key_table;

    localparam int unsigned NR = 4;
    localparam int unsigned KW = 8;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, clr_en, clr_all, req_valid, rsp_ready;
    logic [IW-1:0] wr_idx, clr_idx, req_idx;
    logic [KW-1:0] wr_key;
    logic          req_ready, rsp_valid, rsp_hit;
    logic [KW-1:0] rsp_key;
    logic [IW-1:0] count;

    idx_key_table #(.NR(NR), .KW(KW), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_key    (wr_key),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx),
        .clr_all   (clr_all),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_key   (rsp_key),
        .rsp_hit   (rsp_hit),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr_en;
        logic [IW-1:0] wr_idx;
        logic [KW-1:0] wr_key;
        logic          clr_en;
        logic [IW-1:0] clr_idx;
        logic          clr_all;
        logic          req_valid;
        logic [IW-1:0] req_idx;
        logic          rsp_ready;
        logic          exp_hit;
        logic [KW-1:0] exp_key;
        logic [IW-1:0] exp_count;
    } vec_t;

    vec_t           vecs[$];
    logic [KW:0]    sb[$];   // {hit, key} of accepted requests awaiting consumption
    int             checks = 0;
    int             errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input logic [IW-1:0] exp_count);
        chk("count", 32'(count), 32'(exp_count));
        chk("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("rsp_hit", 32'(rsp_hit), 32'(sb[0][KW]));
            chk("rsp_key", 32'(rsp_key), 32'(sb[0][KW-1:0]));
        end
    endtask

    task automatic step(input vec_t v);
        logic exp_rdy;
        wr_en     = v.wr_en;
        wr_idx    = v.wr_idx;
        wr_key    = v.wr_key;
        clr_en    = v.clr_en;
        clr_idx   = v.clr_idx;
        clr_all   = v.clr_all;
        req_valid = v.req_valid;
        req_idx   = v.req_idx;
        rsp_ready = v.rsp_ready;
        @(negedge clk);
        exp_rdy = (sb.size() == 0) || v.rsp_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (sb.size() != 0 && v.rsp_ready) void'(sb.pop_front());
        if (v.req_valid && exp_rdy) sb.push_back({v.exp_hit, v.exp_key});
        @(posedge clk);
        #1;
        check_outputs(v.exp_count);
    endtask

    // Shorthands: lookup-only, write-only, idle.
    function automatic vec_t rd(input logic [IW-1:0] idx, input logic hit, input logic [KW-1:0] key,
                                input logic [IW-1:0] cnt, input logic rdy);
        return vec_t'{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, idx, rdy, hit, key, cnt};
    endfunction

    function automatic vec_t wr(input logic [IW-1:0] idx, input logic [KW-1:0] key,
                                input logic [IW-1:0] cnt);
        return vec_t'{1'b1, idx, key, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00, cnt};
    endfunction

    function automatic vec_t idle(input logic [IW-1:0] cnt, input logic rdy);
        return vec_t'{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, rdy, 1'b0, 8'h00, cnt};
    endfunction

    initial begin
        rst = 1'b1;
        {wr_en, clr_en, clr_all, req_valid, rsp_ready} = '0;
        {wr_idx, clr_idx, req_idx} = '0;
        wr_key = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_hit", 32'(rsp_hit), 32'd0);
        chk("reset_rsp_key", 32'(rsp_key), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // Lookup on empty table, then writes and back-to-back lookups.
        vecs.push_back(rd(3'd1, 1'b0, 8'h00, 3'd0, 1'b1));
        vecs.push_back(wr(3'd1, 8'hA5, 3'd1));
        vecs.push_back(wr(3'd4, 8'h3C, 3'd2));
        vecs.push_back(rd(3'd4, 1'b1, 8'h3C, 3'd2, 1'b1));
        vecs.push_back(rd(3'd1, 1'b1, 8'hA5, 3'd2, 1'b1));
        vecs.push_back(rd(3'd0, 1'b0, 8'h00, 3'd2, 1'b1));
        vecs.push_back(rd(3'd5, 1'b0, 8'h00, 3'd2, 1'b1));
        // Read of an entry written in the same cycle returns the old contents.
        vecs.push_back(vec_t'{1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1,
                              1'b0, 8'h00, 3'd3});
        vecs.push_back(rd(3'd2, 1'b1, 8'h11, 3'd3, 1'b1));
        // Out-of-range writes/clears are ignored; overwrite keeps count.
        vecs.push_back(wr(3'd0, 8'hFF, 3'd3));
        vecs.push_back(wr(3'd7, 8'hEE, 3'd3));
        vecs.push_back(vec_t'{1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 3'd7, 1'b1,
                              1'b0, 8'h00, 3'd3});
        vecs.push_back(wr(3'd1, 8'h5A, 3'd3));
        vecs.push_back(rd(3'd1, 1'b1, 8'h5A, 3'd3, 1'b1));
        // clr_all plus a write in one cycle leaves just the written entry.
        vecs.push_back(vec_t'{1'b1, 3'd3, 8'h77, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1,
                              1'b0, 8'h00, 3'd1});
        vecs.push_back(rd(3'd3, 1'b1, 8'h77, 3'd1, 1'b1));
        vecs.push_back(rd(3'd1, 1'b0, 8'h00, 3'd1, 1'b1));
        // Clear and write of the same entry: write wins.
        vecs.push_back(vec_t'{1'b1, 3'd3, 8'h12, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b1,
                              1'b0, 8'h00, 3'd1});
        vecs.push_back(rd(3'd3, 1'b1, 8'h12, 3'd1, 1'b1));
        // Clear of an invalid entry is a no-op; clear with same-cycle read sees old entry.
        vecs.push_back(vec_t'{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b1,
                              1'b0, 8'h00, 3'd1});
        vecs.push_back(vec_t'{1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1,
                              1'b1, 8'h12, 3'd0});
        vecs.push_back(rd(3'd3, 1'b0, 8'h00, 3'd0, 1'b1));
        vecs.push_back(wr(3'd1, 8'hC3, 3'd1));
        vecs.push_back(idle(3'd1, 1'b1));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Backpressure: the response must hold while the next request waits.
        step(rd(3'd1, 1'b1, 8'hC3, 3'd1, 1'b1));
        for (int i = 0; i < 3; i++) step(rd(3'd2, 1'b0, 8'h00, 3'd1, 1'b0));
        step(rd(3'd2, 1'b0, 8'h00, 3'd1, 1'b1));
        step(rd(3'd1, 1'b1, 8'hC3, 3'd1, 1'b1));
        step(idle(3'd1, 1'b1));

        // Async reset with a stalled response in flight.
        step(rd(3'd1, 1'b1, 8'hC3, 3'd1, 1'b0));
        #2 rst = 1'b1;
        #1;
        sb.delete();
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= NR; i++) step(rd(IW'(i), 1'b0, 8'h00, 3'd0, 1'b1));
        step(idle(3'd0, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
